// File: rtl/context_switch_sequencer.sv
// context_switch_sequencer: sequences a decoding-context switch for the link/PU context memories.
//
// Shared stage codes live in context_switch_pkg below. Every block that needs
// the stage encoding imports this package.
//
// Ports:
//   clk                  - single clock, rising edge
//   reset                - asynchronous, active-low reset
//   stage_in             - stage requested by the main controller
//   switch_req           - level context-switch request
//   switch_kind          - 0 = advance to the next context, 1 = local refresh
//   global_stage         - stage broadcast to all links and PUs
//   local_context_switch - link/PU local context-switch strobe
//   current_context      - mirror of the link memory address
//   busy                 - stall for the main controller while a switch runs
//   switch_ack           - one-cycle completion pulse
//   switch_err           - one-cycle rejection pulse
//   switch_count         - completed-switch counter, saturating at 0xFFFF
//                          (present only with CONTEXT_SWITCH_STATS_EN defined)
package context_switch_pkg;
    localparam int STAGE_WIDTH = 3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROWTH              = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd5;
    localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = 3'd6;
    localparam logic [STAGE_WIDTH-1:0] STAGE_READ_FROM_MEM       = 3'd7;
endpackage

module context_switch_sequencer
    import context_switch_pkg::*;
#(
    parameter int NUM_CONTEXTS = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STAGE_WIDTH-1:0] stage_in,
    input  logic                   switch_req,
    input  logic                   switch_kind,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   local_context_switch,
    output logic [3:0]             current_context,
    output logic                   busy,
    output logic                   switch_ack,
    output logic                   switch_err
`ifdef CONTEXT_SWITCH_STATS_EN
    ,
    output logic [15:0]            switch_count
`endif
);
    typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] gap_cnt, gap_cnt_nx;
    logic kind, kind_nx;
    logic [STAGE_WIDTH-1:0] resume, resume_nx;
    logic [3:0] ctx_nx;
    logic err_nx;
    logic loading;
    assign loading = (stage_in == STAGE_PARAMETERS_LOADING) || (stage_in == STAGE_MEASUREMENT_LOADING);
    // Only IDLE passes stage_in straight through; every other state is decoded from registers.
    assign global_stage = state == WRITE ? STAGE_WRITE_TO_MEM :
                          state == GAP   ? STAGE_IDLE :
                          state == READ  ? STAGE_READ_FROM_MEM :
                          state == DONE  ? resume : stage_in;
    always_comb begin
        state_nx   = state;
        gap_cnt_nx = gap_cnt;
        kind_nx    = kind;
        resume_nx  = resume;
        ctx_nx     = current_context;
        err_nx     = 1'b0;
        case (state)
            IDLE: if (switch_req) begin
                if (loading) err_nx = 1'b1;
                else begin
                    state_nx  = WRITE;
                    kind_nx   = switch_kind;
                    resume_nx = stage_in;
                end
            end
            WRITE: begin
                state_nx   = GAP;
                gap_cnt_nx = 3'd0;
            end
            GAP: if (gap_cnt == 3'(GAP_CYCLES - 1)) state_nx = READ;
                 else gap_cnt_nx = gap_cnt + 3'd1;
            READ: begin
                state_nx = DONE;
                // Context pointer moves on the DONE-entry edge so it lines up with the ack.
                if (!kind) ctx_nx = (current_context == 4'(NUM_CONTEXTS - 1)) ? 4'd0 : current_context + 4'd1;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Registered outputs are computed from the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            gap_cnt              <= 3'd0;
            kind                 <= 1'b0;
            resume               <= '0;
            current_context      <= 4'd0;
            busy                 <= 1'b0;
            local_context_switch <= 1'b0;
            switch_ack           <= 1'b0;
            switch_err           <= 1'b0;
        end else begin
            state                <= state_nx;
            gap_cnt              <= gap_cnt_nx;
            kind                 <= kind_nx;
            resume               <= resume_nx;
            current_context      <= ctx_nx;
            busy                 <= state_nx != IDLE;
            local_context_switch <= (state_nx == WRITE) && kind_nx;
            switch_ack           <= state_nx == DONE;
            switch_err           <= err_nx;
        end
    end
`ifdef CONTEXT_SWITCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) switch_count <= 16'd0;
        else if (switch_ack && switch_count != 16'hFFFF) switch_count <= switch_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_context_switch_sequencer.sv
// tb_context_switch_sequencer: randomized self-checking bench for context_switch_sequencer.
module tb_context_switch_sequencer;
    import context_switch_pkg::*;
    localparam int NC = 2;
    localparam int G  = 2;
    localparam int LAST = 3 + G;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [STAGE_WIDTH-1:0] stage_in = STAGE_IDLE;
    logic switch_req = 1'b0;
    logic switch_kind = 1'b0;
    logic [STAGE_WIDTH-1:0] global_stage;
    logic local_context_switch;
    logic [3:0] current_context;
    logic busy;
    logic switch_ack;
    logic switch_err;
`ifdef CONTEXT_SWITCH_STATS_EN
    logic [15:0] switch_count;
    int m_count = 0;
`endif
    context_switch_sequencer #(.NUM_CONTEXTS(NC), .GAP_CYCLES(G)) dut (
        .clk(clk),
        .reset(reset),
        .stage_in(stage_in),
        .switch_req(switch_req),
        .switch_kind(switch_kind),
        .global_stage(global_stage),
        .local_context_switch(local_context_switch),
        .current_context(current_context),
        .busy(busy),
        .switch_ack(switch_ack),
        .switch_err(switch_err)
`ifdef CONTEXT_SWITCH_STATS_EN
        ,
        .switch_count(switch_count)
`endif
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    // Model: t counts cycles since the acceptance edge (0 = no switch running).
    int t = 0;
    int m_ctx = 0;
    logic m_kind = 1'b0;
    logic m_err = 1'b0;
    logic [STAGE_WIDTH-1:0] m_resume = STAGE_IDLE;
    int cyc = 0;
    logic [31:0] ack_mask = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        t = 0;
        m_ctx = 0;
        m_kind = 1'b0;
        m_err = 1'b0;
        m_resume = STAGE_IDLE;
`ifdef CONTEXT_SWITCH_STATS_EN
        m_count = 0;
`endif
    endtask
    task automatic check_outputs();
        logic [STAGE_WIDTH-1:0] es;
        es = t == 0 ? stage_in : t == 1 ? STAGE_WRITE_TO_MEM : t <= 1 + G ? STAGE_IDLE :
             t == 2 + G ? STAGE_READ_FROM_MEM : m_resume;
        check("stage", global_stage, es);
        check("busy", busy, t != 0);
        check("lcs", local_context_switch, t == 1 && m_kind);
        check("ack", switch_ack, t == LAST);
        check("err", switch_err, m_err);
        check("ctx", current_context, m_ctx);
`ifdef CONTEXT_SWITCH_STATS_EN
        check("count", switch_count, m_count);
`endif
    endtask
    task automatic model_update();
`ifdef CONTEXT_SWITCH_STATS_EN
        if (t == LAST && m_count < 65535) m_count++;
`endif
        m_err = 1'b0;
        if (t == 0) begin
            if (switch_req) begin
                if (stage_in == STAGE_PARAMETERS_LOADING || stage_in == STAGE_MEASUREMENT_LOADING) m_err = 1'b1;
                else begin
                    t = 1;
                    m_kind = switch_kind;
                    m_resume = stage_in;
                end
            end
        end else if (t == LAST) t = 0;
        else begin
            t++;
            if (t == LAST && !m_kind) m_ctx = (m_ctx + 1) % NC;
        end
    endtask
    task automatic step(input logic rq, input logic kd, input logic [STAGE_WIDTH-1:0] st, input logic rn);
        @(negedge clk);
        switch_req = rq;
        switch_kind = kd;
        stage_in = st;
        reset = rn;
        #1;
        if (!rn) model_reset();
        check_outputs();
        if (switch_ack && cyc < 32) ack_mask[cyc] = 1'b1;
        cyc++;
        @(posedge clk);
        if (rn) model_update();
    endtask
    initial begin
        step(0, 0, STAGE_IDLE, 0);
        step(0, 0, STAGE_GROWTH, 0);
        // Advance, then a second advance that wraps the context pointer.
        step(1, 0, STAGE_GROWTH, 1);
        repeat (6) step(0, 0, STAGE_GROWTH, 1);
        check("ctx_after_adv", current_context, 1);
        step(1, 0, STAGE_MERGE, 1);
        repeat (6) step(0, 0, STAGE_PEELING, 1);
        check("ctx_after_wrap", current_context, 0);
        // Local refresh.
        step(1, 1, STAGE_PEELING, 1);
        repeat (6) step(0, 1, STAGE_GROWTH, 1);
        // Rejections.
        step(1, 0, STAGE_MEASUREMENT_LOADING, 1);
        step(0, 0, STAGE_MEASUREMENT_LOADING, 1);
        step(1, 1, STAGE_PARAMETERS_LOADING, 1);
        step(0, 0, STAGE_GROWTH, 1);
        // Reset during the gap.
        step(1, 0, STAGE_GROWTH, 1);
        step(0, 0, STAGE_GROWTH, 1);
        step(0, 0, STAGE_GROWTH, 1);
        step(0, 0, STAGE_MERGE, 0);
        repeat (7) step(0, 0, STAGE_MERGE, 1);
        check("ctx_after_abort", current_context, 0);
        // Back-to-back with request held high.
        step(0, 0, STAGE_GROWTH, 0);
        cyc = 0;
        ack_mask = 0;
        repeat (21) step(1, 0, STAGE_GROWTH, 1);
        check("b2b_acks", ack_mask, (32'd1 << 5) | (32'd1 << 11) | (32'd1 << 17));
`ifdef CONTEXT_SWITCH_STATS_EN
        check("b2b_count", switch_count, 3);
`endif
        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 6, 1'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 99) != 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
